// File: rtl/riscv_pkg.sv
// Shared types and widths for the core's memory-side blocks.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        MR_IDLE,
        MR_WAIT,
        MR_RESP
    } memrsp_state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised data RAM: byte-enabled synchronous write and a registered read
// of the same index at the same edge.
module dmem_array
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [IDX_W-1:0]  widx,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata
);

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];
    logic [XLEN-1:0] rdata_q;

    // NOTE: the array and its read register have no reset; contents are undefined
    // until written, and a reset loop over every word would not map onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) mem_q[widx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata_q <= mem_q[widx];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready request and
// response channels, with separate configurable read and write latencies.
module dmem_responder
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LATENCY  = 2,
    parameter int WR_LATENCY  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [XLEN-1:0]  req_addr,
    input  logic [XLEN-1:0]  req_wdata,
    input  logic [BE_W-1:0]  req_be,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_rdata,
    output logic             rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] RD_CNT     = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_CNT     = CNT_W'(WR_LATENCY - 1);
    localparam logic [XLEN:0]    ADDR_LIMIT = (XLEN+1)'(4 * DEPTH_WORDS);

    memrsp_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lat_cnt;
    logic             err_q, we_q;
    logic [IDX_W-1:0] idx_q;
    logic             accept, addr_err;
    logic             arr_we;
    logic [IDX_W-1:0] arr_idx;
    logic [XLEN-1:0]  arr_rdata;

    assign accept   = (state_q == MR_IDLE) && req_valid;
    assign addr_err = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr} >= ADDR_LIMIT);
    assign lat_cnt  = req_we ? WR_CNT : RD_CNT;
    assign arr_we   = accept && req_we && !addr_err;
    // Index follows the request while idle, then freezes so the read register holds the load word.
    assign arr_idx  = (state_q == MR_IDLE) ? req_addr[IDX_W+1:2] : idx_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MR_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MR_IDLE: begin
                if (req_valid) begin
                    cnt_d   = lat_cnt;
                    state_d = (lat_cnt != '0) ? MR_WAIT : MR_RESP;
                end
            end
            MR_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_d == '0) state_d = MR_RESP;
            end
            MR_RESP: begin
                if (rsp_ready) state_d = MR_IDLE;
            end
            default: state_d = MR_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        case (state_q)
            MR_IDLE: req_ready = 1'b1;
            MR_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (err_q || we_q) ? '0 : arr_rdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            we_q  <= 1'b0;
            idx_q <= '0;
        end else if (accept) begin
            err_q <= addr_err;
            we_q  <= req_we;
            idx_q <= req_addr[IDX_W+1:2];
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .be    (req_be),
        .widx  (arr_idx),
        .wdata (req_wdata),
        .rdata (arr_rdata)
    );

endmodule
